// File: rtl/renderiza_tabuleiro.sv
// Board renderer: two-stage pixel pipeline that maps sync-generator coordinates
// onto a N x N grid of cells, fetches the cell code from the board RAM and
// produces RGB with grid lines, a blinking cursor and delayed syncs.
module renderiza_tabuleiro #(
  parameter int X0      = 160,
  parameter int Y0      = 80,
  parameter int LOG_CEL = 5,
  parameter int N       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] linha,
  input  logic [9:0] coluna,
  input  logic       regiaoAtiva,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic [3:0] cursor_linha,
  input  logic [3:0] cursor_coluna,
  input  logic       mostra_navios,
  output logic [6:0] mem_addr,
  input  logic [1:0] mem_dado,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       h_sync,
  output logic       v_sync
);

  localparam int SPAN = N << LOG_CEL;
  localparam int CEL  = 1 << LOG_CEL;
  localparam int NB   = $clog2(N) + 1;
  localparam logic [LOG_CEL-1:0] OFF_LAST = LOG_CEL'(CEL - 1);
  localparam logic [LOG_CEL-1:0] OFF_PREV = LOG_CEL'(CEL - 2);

  // Stage 1 combinational terms
  logic [10:0] col_ext, lin_ext;
  logic        on_x, on_y, on_board;
  logic [9:0]  dx, dy, cel_col, cel_row;
  logic [LOG_CEL-1:0] off_x, off_y;
  logic        border_x, border_y, grid_d, cursor_ok, cursor_d;
  logic [9:0]  addr_acc [NB+1];
  logic [6:0]  mem_addr_d;

  // Stage 1 registers
  logic [6:0]  mem_addr_q;
  logic        onb_q, grid_q, cursor_q, mostra_q, act1_q, hs1_q, vs1_q;
  // Stage 2 registers
  logic        act2_q, hs2_q, vs2_q;
  logic [11:0] rgb_q, rgb_d;
  logic [4:0]  frame_q;

  // Board-window test and cell/offset decomposition for the incoming pixel
  always_comb begin
    col_ext  = {1'b0, coluna};
    lin_ext  = {1'b0, linha};
    on_x     = (col_ext >= 11'(X0)) && (col_ext < 11'(X0 + SPAN));
    on_y     = (lin_ext >= 11'(Y0)) && (lin_ext < 11'(Y0 + SPAN));
    on_board = on_x && on_y;
    dx       = coluna - 10'(X0);
    dy       = linha  - 10'(Y0);
    cel_col  = dx >> LOG_CEL;
    cel_row  = dy >> LOG_CEL;
    off_x    = dx[LOG_CEL-1:0];
    off_y    = dy[LOG_CEL-1:0];
    grid_d   = (off_x == '0) || (off_y == '0) ||
               (dx == 10'(SPAN - 1)) || (dy == 10'(SPAN - 1));
    border_x = (off_x == '0) || (off_x == LOG_CEL'(1)) ||
               (off_x == OFF_PREV) || (off_x == OFF_LAST);
    border_y = (off_y == '0) || (off_y == LOG_CEL'(1)) ||
               (off_y == OFF_PREV) || (off_y == OFF_LAST);
    // Out-of-range cursor coordinates can never match a cell
    cursor_ok = ({6'b0, cursor_linha} < 10'(N)) && ({6'b0, cursor_coluna} < 10'(N));
    cursor_d  = cursor_ok && (cel_row == {6'b0, cursor_linha}) &&
                (cel_col == {6'b0, cursor_coluna}) && (border_x || border_y);
  end

  // row*N built as a chain of shifted adds, one term per set bit of N
  assign addr_acc[0] = cel_col;
  for (genvar gi = 0; gi < NB; gi++) begin : g_mul
    if (((N >> gi) & 1) == 1) begin : g_term
      assign addr_acc[gi+1] = addr_acc[gi] + (cel_row << gi);
    end else begin : g_skip
      assign addr_acc[gi+1] = addr_acc[gi];
    end
  end

  // Off-board pixels keep the last address so the RAM is not disturbed
  assign mem_addr_d = on_board ? 7'(addr_acc[NB]) : mem_addr_q;

  // Stage 1: address, pixel flags and first delay tap of the syncs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q <= '0;
      onb_q      <= 1'b0;
      grid_q     <= 1'b0;
      cursor_q   <= 1'b0;
      mostra_q   <= 1'b0;
      act1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
    end else begin
      mem_addr_q <= mem_addr_d;
      onb_q      <= on_board;
      grid_q     <= grid_d;
      cursor_q   <= cursor_d;
      mostra_q   <= mostra_navios;
      act1_q     <= regiaoAtiva;
      hs1_q      <= h_sync_in;
      vs1_q      <= v_sync_in;
    end
  end

  // Stage 2 colour priority: blanking, background, cursor, grid, cell code
  always_comb begin
    rgb_d = 12'h000;
    if (!act2_q_next_src()) rgb_d = 12'h000;
    else if (!onb_q)                 rgb_d = 12'h001;
    else if (cursor_q && frame_q[4]) rgb_d = 12'hFF0;
    else if (grid_q)                 rgb_d = 12'hFFF;
    else begin
      case (mem_dado)
        2'd1:    rgb_d = mostra_q ? 12'h888 : 12'h00A;
        2'd2:    rgb_d = 12'hF00;
        2'd3:    rgb_d = 12'hAAA;
        default: rgb_d = 12'h00A;
      endcase
    end
  end

  // The colour is registered at the same edge that the second sync tap is,
  // so it is qualified by the first-tap active flag of the same pixel.
  function automatic logic act2_q_next_src();
    return act1_q;
  endfunction

  // Stage 2: colour register and second delay tap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q  <= '0;
      act2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else begin
      rgb_q  <= rgb_d;
      act2_q <= act1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  // Frame counter advances on each falling edge of the incoming v_sync
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     frame_q <= '0;
    else if (vs1_q && !v_sync_in)   frame_q <= frame_q + 5'd1;
  end

  assign mem_addr = mem_addr_q;
  assign vga_r    = rgb_q[11:8];
  assign vga_g    = rgb_q[7:4];
  assign vga_b    = rgb_q[3:0];
  assign h_sync   = hs2_q;
  assign v_sync   = vs2_q;

  logic unused_act2;
  assign unused_act2 = act2_q;

endmodule

// File: doc/renderiza_tabuleiro.md
RENDERIZA_TABULEIRO -- requirements
Module: renderiza_tabuleiro

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- X0, 160, first board pixel column
- Y0, 80, first board pixel line
- LOG_CEL, 5, log2 of cell size in pixels (32x32 cells)
- N, 10, cells per board side
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, 25 MHz pixel clock
- reset, in, 1, asynchronous active-low reset
- linha, in, 10, current line index from the sync generator
- coluna, in, 10, current column index from the sync generator
- regiaoAtiva, in, 1, active-area flag from the sync generator
- h_sync_in, in, 1, horizontal sync from the sync generator, active-low
- v_sync_in, in, 1, vertical sync from the sync generator, active-low
- cursor_linha, in, 4, cursor cell row
- cursor_coluna, in, 4, cursor cell column
- mostra_navios, in, 1, 1 = draw unhit ships, 0 = draw unhit ships as water
- mem_addr, out, 7, board RAM read address
- mem_dado, in, 2, board RAM data, valid 1 cycle after mem_addr
- vga_r, out, 4, red component
- vga_g, out, 4, green component
- vga_b, out, 4, blue component
- h_sync, out, 1, delayed horizontal sync
- v_sync, out, 1, delayed vertical sync
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low.

Function
REQ-004 SHALL be a 2-stage pipeline: all outputs for pixel (linha, coluna) appear exactly 2 clk edges after that pixel is presented.
REQ-005 SHALL delay h_sync_in, v_sync_in and regiaoAtiva by exactly 2 registers so that the syncs stay aligned with the RGB outputs.
REQ-006 Stage 1 SHALL compute dx = coluna-X0 and dy = linha-Y0; the pixel is on the board when 0 <= dx < N<<LOG_CEL and 0 <= dy < N<<LOG_CEL, evaluated as unsigned comparisons after range checks with no wrap.
REQ-007 Stage 1 SHALL compute cell col = dx>>LOG_CEL, cell row = dy>>LOG_CEL, and register mem_addr = row*10+col using shifts and adds only (no multiplier or divider); range 0..99.
REQ-008 When the pixel is off the board, mem_addr SHALL hold its previous value; mem_dado is ignored.
REQ-009 Stage 1 SHALL register the following flags: on-board, grid line (dx[LOG_CEL-1:0]==0 or dy[LOG_CEL-1:0]==0, or dx or dy equal to N<<LOG_CEL minus 1), and cursor-border (cell equals the cursor cell and the pixel offset within the cell is 0, 1, 30 or 31 in x or y).
REQ-010 Cell codes from mem_dado SHALL be 0 = water, 1 = ship, 2 = hit, 3 = miss.
REQ-011 Stage 2 SHALL select the colour {r,g,b} by priority:
- delayed regiaoAtiva = 0: 000
- off board: 001 (dark blue background)
- cursor-border and blink phase = 1: FF0
- grid line: FFF
- code 1 with mostra_navios = 1: 888
- code 1 with mostra_navios = 0: 00A
- code 0: 00A
- code 2: F00
- code 3: AAA
REQ-012 A cursor with cursor_linha > 9 or cursor_coluna > 9 SHALL never be drawn.
REQ-013 SHALL keep a 5-bit frame counter that increments once per frame, on the clk edge where a registered copy of v_sync_in is 1 and v_sync_in is 0; it wraps 31 -> 0.
REQ-014 Blink phase SHALL be bit 4 of the frame counter, so the cursor is visible for 16 frames and hidden for 16 frames.
REQ-015 Cursor and mostra_navios inputs SHALL be sampled in stage 1 each pixel; mid-frame changes take effect at the next pixel, with no frame-level latching.

Reset
REQ-016 While reset = 0, the outputs SHALL be:
- vga_r, vga_g, vga_b, mem_addr: 0
- h_sync, v_sync: 1
- all pipeline flags and the frame counter: 0
REQ-017 On reset release, correct outputs SHALL appear 2 cycles after the first sampled pixel, with no residual data from before reset.
REQ-018 Asserting reset mid-line SHALL immediately force the REQ-016 values, without waiting for a clk edge.

Verification
REQ-019 Present pixel (linha=80, coluna=160), regiaoAtiva=1, board all 0 -> mem_addr=0 after 1 cycle; {r,g,b}=FFF (grid) after 2 cycles.
REQ-020 Present pixel (linha=80+32*3+5, coluna=160+32*7+5), RAM returns 2 -> mem_addr=37 after 1 cycle; {r,g,b}=F00 after 2 cycles.
REQ-021 Code 1 cell at interior pixel with mostra_navios=0 -> 00A; the same pixel with mostra_navios=1 -> 888.
REQ-022 Cursor (4,4), frame counter forced through 16 v_sync falling edges, pixel at offset (0,0) of cell (4,4) -> FF0 for frames 16..31; FFF (grid) for frames 0..15.
REQ-023 Pixel (linha=10, coluna=10) or regiaoAtiva=0 -> 001 or 000 respectively; h_sync_in toggled at cycle t -> h_sync toggles at t+2.
REQ-024 Pulse reset low for 3 cycles mid-line -> all outputs take REQ-016 values asynchronously and the frame counter reads 0 after release.
